// File: rtl/axilwb_arb_pkg.sv
// Shared types for the two-port Wishbone arbiter: FSM state encoding and port ids.
package axilwb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2,
        FLUSH   = 2'd3
    } arb_state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/axilwb_watchdog.sv
// Stuck-cycle watchdog: counts cycles without a slave response and flags all-ones.
module axilwb_watchdog #(
    parameter int LGTIMEOUT = 8
) (
    input  logic i_clk,
    input  logic w_reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    generate
        if (LGTIMEOUT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            logic [LGTIMEOUT-1:0] count_q;
            logic [LGTIMEOUT-1:0] count_d;

            always_comb begin
                count_d = count_q;
                if (clear) begin
                    count_d = '0;
                end else if (run) begin
                    count_d = count_q + LGTIMEOUT'(1);
                end
            end

            always_ff @(posedge i_clk) begin
                if (w_reset) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end

            assign expired = &count_q;
        end
    endgenerate

endmodule

// File: rtl/axilwb_arbiter.sv
// Two-to-one pipelined Wishbone arbiter (A = read bridge, B = write bridge) with
// round-robin tie break, whole-cycle ownership and a response watchdog.
module axilwb_arbiter
    import axilwb_arb_pkg::*;
#(
    parameter int AW        = 26,
    parameter int DW        = 32,
    parameter int LGTIMEOUT = 8
) (
    input  logic              i_clk,
    input  logic              w_reset,
    input  logic              i_a_cyc,
    input  logic              i_a_stb,
    input  logic              i_a_we,
    input  logic [AW-1:0]     i_a_addr,
    input  logic [DW-1:0]     i_a_data,
    input  logic [DW/8-1:0]   i_a_sel,
    output logic              o_a_stall,
    output logic              o_a_ack,
    output logic              o_a_err,
    output logic [DW-1:0]     o_a_data,
    input  logic              i_b_cyc,
    input  logic              i_b_stb,
    input  logic              i_b_we,
    input  logic [AW-1:0]     i_b_addr,
    input  logic [DW-1:0]     i_b_data,
    input  logic [DW/8-1:0]   i_b_sel,
    output logic              o_b_stall,
    output logic              o_b_ack,
    output logic              o_b_err,
    output logic [DW-1:0]     o_b_data,
    output logic              o_cyc,
    output logic              o_stb,
    output logic              o_we,
    output logic [AW-1:0]     o_addr,
    output logic [DW-1:0]     o_data,
    output logic [DW/8-1:0]   o_sel,
    input  logic              i_stall,
    input  logic              i_ack,
    input  logic              i_err,
    input  logic [DW-1:0]     i_data
);

    arb_state_t state_q, state_d;
    logic       r_last_q, r_last_d;
    logic       grant_a, grant_b;
    logic       owner_cyc, owner_stb;
    logic       wd_expired, wd_fire, wd_clear;

    // Bus routing is combinational from the registered state; reset masks the grant.
    always_comb begin
        grant_a   = !w_reset && (state_q == GRANT_A);
        grant_b   = !w_reset && (state_q == GRANT_B);
        owner_cyc = (grant_a && i_a_cyc) || (grant_b && i_b_cyc);
        owner_stb = (grant_a && i_a_stb) || (grant_b && i_b_stb);
        wd_fire   = owner_cyc && wd_expired;
        o_cyc     = owner_cyc && !wd_fire;
        o_stb     = o_cyc && owner_stb;
        o_we      = 1'b0;
        o_addr    = '0;
        o_data    = '0;
        o_sel     = '0;
        if (grant_a) begin
            o_we   = i_a_we;
            o_addr = i_a_addr;
            o_data = i_a_data;
            o_sel  = i_a_sel;
        end else if (grant_b) begin
            o_we   = i_b_we;
            o_addr = i_b_addr;
            o_data = i_b_data;
            o_sel  = i_b_sel;
        end
        o_a_stall = grant_a ? i_stall : 1'b1;
        o_b_stall = grant_b ? i_stall : 1'b1;
        o_a_ack   = grant_a && o_cyc && i_ack;
        o_b_ack   = grant_b && o_cyc && i_ack;
        o_a_err   = grant_a && ((o_cyc && i_err) || wd_fire);
        o_b_err   = grant_b && ((o_cyc && i_err) || wd_fire);
        o_a_data  = i_data;
        o_b_data  = i_data;
    end

    always_comb begin
        state_d  = state_q;
        r_last_d = r_last_q;
        case (state_q)
            IDLE: begin
                if (i_a_cyc && (!i_b_cyc || r_last_q == PORT_B)) begin
                    state_d = GRANT_A;
                end else if (i_b_cyc) begin
                    state_d = GRANT_B;
                end
            end
            GRANT_A: begin
                if (!i_a_cyc) begin
                    r_last_d = PORT_A;
                    state_d  = i_b_cyc ? GRANT_B : IDLE;
                end else if (wd_fire) begin
                    r_last_d = PORT_A;
                    state_d  = FLUSH;
                end
            end
            GRANT_B: begin
                if (!i_b_cyc) begin
                    r_last_d = PORT_B;
                    state_d  = i_a_cyc ? GRANT_A : IDLE;
                end else if (wd_fire) begin
                    r_last_d = PORT_B;
                    state_d  = FLUSH;
                end
            end
            FLUSH: begin
                // Hold off both ports until the aborted owner has let go of cyc.
                if ((r_last_q == PORT_A) ? !i_a_cyc : !i_b_cyc) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        wd_clear = !o_cyc || i_ack || i_err || (state_d != state_q);
    end

    always_ff @(posedge i_clk) begin
        if (w_reset) begin
            state_q  <= IDLE;
            r_last_q <= PORT_B;
        end else begin
            state_q  <= state_d;
            r_last_q <= r_last_d;
        end
    end

    axilwb_watchdog #(
        .LGTIMEOUT (LGTIMEOUT)
    ) u_watchdog (
        .i_clk   (i_clk),
        .w_reset (w_reset),
        .clear   (wd_clear),
        .run     (o_cyc),
        .expired (wd_expired)
    );

endmodule

// File: tb/tb_axilwb_arbiter.sv
// Bench for axilwb_arbiter: directed table, corner sequences and random traffic,
// all checked every cycle against an ownership-level reference model.
module tb_axilwb_arbiter;

    localparam int AW    = 26;
    localparam int DW    = 32;
    localparam int SW    = DW / 8;
    localparam int LGT   = 4;
    localparam int LIMIT = (1 << LGT) - 1;
    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic i_clk = 1'b0;
    logic w_reset;
    logic i_a_cyc, i_a_stb, i_a_we, i_b_cyc, i_b_stb, i_b_we;
    logic [AW-1:0] i_a_addr, i_b_addr, o_addr;
    logic [DW-1:0] i_a_data, i_b_data, o_data, i_data, o_a_data, o_b_data;
    logic [SW-1:0] i_a_sel, i_b_sel, o_sel;
    logic o_a_stall, o_a_ack, o_a_err, o_b_stall, o_b_ack, o_b_err;
    logic o_cyc, o_stb, o_we, i_stall, i_ack, i_err;

    always #5 i_clk = ~i_clk;

    axilwb_arbiter #(.AW(AW), .DW(DW), .LGTIMEOUT(LGT)) dut (
        .i_clk(i_clk), .w_reset(w_reset),
        .i_a_cyc(i_a_cyc), .i_a_stb(i_a_stb), .i_a_we(i_a_we), .i_a_addr(i_a_addr),
        .i_a_data(i_a_data), .i_a_sel(i_a_sel), .o_a_stall(o_a_stall), .o_a_ack(o_a_ack),
        .o_a_err(o_a_err), .o_a_data(o_a_data),
        .i_b_cyc(i_b_cyc), .i_b_stb(i_b_stb), .i_b_we(i_b_we), .i_b_addr(i_b_addr),
        .i_b_data(i_b_data), .i_b_sel(i_b_sel), .o_b_stall(o_b_stall), .o_b_ack(o_b_ack),
        .o_b_err(o_b_err), .o_b_data(o_b_data),
        .o_cyc(o_cyc), .o_stb(o_stb), .o_we(o_we), .o_addr(o_addr), .o_data(o_data),
        .o_sel(o_sel), .i_stall(i_stall), .i_ack(i_ack), .i_err(i_err), .i_data(i_data)
    );

    // Reference model: who owns the bus, whether it is being flushed, last owner,
    // and how many cycles the current owner has waited for a response.
    int m_owner = 0;   // 0 none, 1 A, 2 B
    bit m_flush = 1'b0;
    int m_last  = 1;   // 0 A, 1 B
    int m_wait  = 0;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic settle_and_check();
        bit ga, gb, xc, xs, expire, ecyc;
        logic [8:0]   e_ctl, a_ctl;
        logic [127:0] e_bus, a_bus;
        #2;
        ga     = !w_reset && !m_flush && (m_owner == 1);
        gb     = !w_reset && !m_flush && (m_owner == 2);
        xc     = ga ? i_a_cyc : (gb ? i_b_cyc : 1'b0);
        xs     = ga ? i_a_stb : (gb ? i_b_stb : 1'b0);
        expire = xc && (m_wait == LIMIT);
        ecyc   = xc && !expire;
        e_ctl  = {ecyc, ecyc && xs, ga ? i_a_we : (gb ? i_b_we : 1'b0),
                  ga ? i_stall : 1'b1, ga && ecyc && i_ack, ga && ((ecyc && i_err) || expire),
                  gb ? i_stall : 1'b1, gb && ecyc && i_ack, gb && ((ecyc && i_err) || expire)};
        a_ctl  = {o_cyc, o_stb, o_we, o_a_stall, o_a_ack, o_a_err, o_b_stall, o_b_ack, o_b_err};
        e_bus  = {2'b00, ga ? i_a_addr : (gb ? i_b_addr : '0), ga ? i_a_data : (gb ? i_b_data : '0),
                  ga ? i_a_sel : (gb ? i_b_sel : '0), i_data, i_data};
        a_bus  = {2'b00, o_addr, o_data, o_sel, o_a_data, o_b_data};
        chk("model_ctrl", 128'(a_ctl), 128'(e_ctl));
        chk("model_bus", a_bus, e_bus);
    endtask

    task automatic advance();
        bit xc, oc;
        if (w_reset) begin
            m_owner = 0; m_flush = 1'b0; m_last = 1; m_wait = 0;
        end else if (m_owner == 0) begin
            if (i_a_cyc && (!i_b_cyc || m_last == 1)) m_owner = 1;
            else if (i_b_cyc) m_owner = 2;
            m_wait = 0;
        end else if (m_flush) begin
            if (!(m_owner == 1 ? i_a_cyc : i_b_cyc)) begin
                m_owner = 0; m_flush = 1'b0;
            end
        end else begin
            xc = (m_owner == 1) ? i_a_cyc : i_b_cyc;
            oc = (m_owner == 1) ? i_b_cyc : i_a_cyc;
            if (!xc) begin
                m_last = m_owner - 1; m_owner = oc ? 3 - m_owner : 0; m_wait = 0;
            end else if (m_wait == LIMIT) begin
                m_flush = 1'b1; m_last = m_owner - 1; m_wait = 0;
            end else if (i_ack || i_err) begin
                m_wait = 0;
            end else begin
                m_wait++;
            end
        end
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic step();
        settle_and_check();
        advance();
    endtask

    typedef struct {
        bit rst, a_cyc, a_stb, b_cyc, b_stb, ack;
        bit e_cyc, e_we, e_a_stall, e_b_stall, e_a_ack, e_b_ack;
    } vec_t;
    vec_t tbl[17];

    initial begin
        int acks, err_at;
        w_reset = 1'b1; i_a_cyc = 1'b0; i_a_stb = 1'b0; i_a_we = 1'b0;
        i_b_cyc = 1'b0; i_b_stb = 1'b0; i_b_we = 1'b1;
        i_a_addr = AW'(32'h10); i_a_data = 32'h0; i_a_sel = '1;
        i_b_addr = AW'(32'h20); i_b_data = 32'h12345678; i_b_sel = '1;
        i_stall = 1'b0; i_ack = 1'b0; i_err = 1'b0; i_data = 32'h0;

        //            rst a_c a_s b_c b_s ack | cyc we a_st b_st a_ack b_ack
        tbl[0]  = '{H, L, L, L, L, L,  L, L, H, H, L, L};
        tbl[1]  = '{L, H, H, H, H, L,  L, L, H, H, L, L};
        tbl[2]  = '{L, H, H, H, H, L,  H, L, L, H, L, L};
        tbl[3]  = '{L, H, L, H, H, H,  H, L, L, H, H, L};
        tbl[4]  = '{L, L, L, H, H, L,  L, L, L, H, L, L};
        tbl[5]  = '{L, L, L, H, H, L,  H, H, H, L, L, L};
        tbl[6]  = '{L, L, L, H, L, H,  H, H, H, L, L, H};
        tbl[7]  = '{L, L, L, L, L, L,  L, H, H, L, L, L};
        tbl[8]  = '{L, H, H, H, H, L,  L, L, H, H, L, L};
        tbl[9]  = '{L, H, H, H, H, L,  H, L, L, H, L, L};
        tbl[10] = '{L, L, L, H, H, L,  L, L, L, H, L, L};
        tbl[11] = '{L, L, L, H, H, L,  H, H, H, L, L, L};
        tbl[12] = '{H, L, L, H, H, L,  L, L, H, H, L, L};
        tbl[13] = '{L, L, L, H, H, L,  L, L, H, H, L, L};
        tbl[14] = '{L, L, L, H, H, L,  H, H, H, L, L, L};
        tbl[15] = '{L, L, L, L, L, L,  L, H, H, L, L, L};
        tbl[16] = '{L, L, L, L, L, L,  L, L, H, H, L, L};

        @(negedge i_clk);
        for (int i = 0; i < 17; i++) begin
            w_reset = tbl[i].rst; i_a_cyc = tbl[i].a_cyc; i_a_stb = tbl[i].a_stb;
            i_b_cyc = tbl[i].b_cyc; i_b_stb = tbl[i].b_stb; i_ack = tbl[i].ack;
            settle_and_check();
            chk($sformatf("vec%0d", i),
                128'({o_cyc, o_we, o_a_stall, o_b_stall, o_a_ack, o_b_ack}),
                128'({tbl[i].e_cyc, tbl[i].e_we, tbl[i].e_a_stall, tbl[i].e_b_stall,
                      tbl[i].e_a_ack, tbl[i].e_b_ack}));
            $display("vec%0d applied: cyc=%b a_ack=%b b_ack=%b", i, o_cyc, o_a_ack, o_b_ack);
            advance();
        end

        // Single read: ack two cycles after the strobe.
        i_a_cyc = 1'b1; i_a_stb = 1'b1;
        settle_and_check();
        chk("read_wait", 128'({o_cyc, o_a_stall}), 128'(2'b01));
        advance();
        settle_and_check();
        chk("read_grant", 128'({o_cyc, o_stb, o_addr}), 128'({2'b11, AW'(32'h10)}));
        advance();
        i_a_stb = 1'b0;
        step();
        i_ack = 1'b1; i_data = 32'hDEADBEEF;
        settle_and_check();
        chk("read_ack", 128'({o_a_ack, o_a_data, o_b_ack, o_b_stall}), 128'({1'b1, 32'hDEADBEEF, 2'b01}));
        advance();
        i_ack = 1'b0; i_a_cyc = 1'b0;
        step();
        step();

        // Back-to-back: A runs three pipelined reads while B waits.
        acks = 0;
        i_a_cyc = 1'b1; i_a_stb = 1'b1;
        step();
        i_b_cyc = 1'b1; i_b_stb = 1'b1;
        for (int k = 0; k < 5; k++) begin
            i_ack = (k >= 1 && k <= 3); i_a_stb = (k < 3); i_a_cyc = (k < 4);
            settle_and_check();
            acks += int'(o_a_ack);
            advance();
        end
        i_ack = 1'b0;
        chk("b2b_acks", 128'(acks), 128'(3));
        settle_and_check();
        chk("handover", 128'({o_cyc, o_we, o_addr, o_data}), 128'({2'b11, AW'(32'h20), 32'h12345678}));
        advance();
        i_b_cyc = 1'b0; i_b_stb = 1'b0;
        step();

        // Watchdog: A strobes once and the slave never answers.
        err_at = -1;
        i_a_cyc = 1'b1; i_a_stb = 1'b1;
        step();
        for (int c = 1; c <= 40 && err_at < 0; c++) begin
            i_a_stb = (c == 1);
            settle_and_check();
            if (o_a_err) begin
                err_at = c;
                chk("wd_cyc_low", 128'(o_cyc), 128'(1'b0));
            end
            advance();
        end
        chk("wd_cycle", 128'(err_at), 128'(16));
        for (int c = 0; c < 3; c++) begin
            settle_and_check();
            chk("flush_hold", 128'({o_cyc, o_a_stall, o_a_err}), 128'(3'b010));
            advance();
        end
        i_a_cyc = 1'b0; i_b_cyc = 1'b1; i_b_stb = 1'b1;
        step();
        step();
        settle_and_check();
        chk("after_flush_b", 128'({o_cyc, o_b_stall}), 128'(2'b10));
        advance();

        // Slave error on B, then the watchdog restarts from zero.
        i_b_stb = 1'b0; i_err = 1'b1;
        settle_and_check();
        chk("slave_err", 128'({o_b_err, o_a_err}), 128'(2'b10));
        advance();
        i_err = 1'b0;
        err_at = -1;
        for (int c = 1; c <= 40 && err_at < 0; c++) begin
            settle_and_check();
            if (o_b_err) err_at = c;
            advance();
        end
        chk("wd_after_err", 128'(err_at), 128'(16));
        i_b_cyc = 1'b0;
        step();
        step();

        // Reset while A holds a stalled strobe.
        i_a_cyc = 1'b1; i_a_stb = 1'b1; i_stall = 1'b1;
        step();
        step();
        w_reset = 1'b1;
        settle_and_check();
        chk("rst_outputs", 128'({o_cyc, o_stb, o_a_stall, o_b_stall, o_a_ack, o_a_err, o_addr}),
            128'({6'b001100, AW'(0)}));
        advance();
        w_reset = 1'b0;
        settle_and_check();
        chk("rst_idle", 128'(o_cyc), 128'(1'b0));
        advance();
        settle_and_check();
        chk("rst_regrant", 128'(o_cyc), 128'(1'b1));
        advance();
        i_a_cyc = 1'b0; i_stall = 1'b0;
        step();

        // Random traffic with occasional silent-slave stretches.
        begin
            int quiet = 0;
            for (int n = 0; n < 3000; n++) begin
                if (quiet > 0) quiet--;
                else if ($urandom_range(99) == 0) quiet = 40;
                if (quiet == 0) begin
                    i_a_cyc = i_a_cyc ? ($urandom_range(7) != 0) : ($urandom_range(3) == 0);
                    i_b_cyc = i_b_cyc ? ($urandom_range(7) != 0) : ($urandom_range(3) == 0);
                end
                i_a_stb = i_a_cyc && ($urandom_range(1) == 1);
                i_b_stb = i_b_cyc && ($urandom_range(1) == 1);
                i_a_we = ($urandom_range(1) == 1); i_b_we = ($urandom_range(1) == 1);
                i_a_addr = AW'($urandom); i_b_addr = AW'($urandom);
                i_a_data = $urandom; i_b_data = $urandom; i_data = $urandom;
                i_a_sel = SW'($urandom); i_b_sel = SW'($urandom);
                i_stall = ($urandom_range(2) == 0);
                i_ack = (quiet == 0) && ($urandom_range(3) == 0);
                i_err = (quiet == 0) && ($urandom_range(31) == 0);
                w_reset = ($urandom_range(499) == 0);
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
